// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the MEM->WB stage.
// The stage adds perf counters when MEM_WB_PERF_EN is defined.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

  localparam int DATA_W_D = 32;
  localparam int WN_W_D   = 5;
  localparam int WB_W_D   = 2;

  function automatic int payload_w(
    input int wb_w,
    input int wn_w,
    input int data_w
  );
    return wb_w + wn_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// Generic 2-entry skid buffer: main output register plus one
// overflow register, with a registered in_ready and a sync flush.
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int PAYLOAD_W = payload_w(WB_W_D, WN_W_D, DATA_W_D)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_e          state_q;
  skid_state_e          state_d;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] main_d;
  logic [PAYLOAD_W-1:0] skid_q;
  logic [PAYLOAD_W-1:0] skid_d;
  logic                 rdy_q;
  logic                 accept;
  logic                 retire;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & rdy_q;
  assign retire    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (retire && !accept) begin
          state_d = EMPTY;
        end else if (retire && accept) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID;
        end
      end
      SKID: begin
        if (retire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // flush squashes held beats and any beat offered this cycle
    if (Flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != SKID);
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with skid buffer and forwarding tap.
// Define MEM_WB_PERF_EN to add perf_stall / perf_beats counters.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int WN_W   = WN_W_D,
  parameter int WB_W   = WB_W_D
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB_MEM,
  input  logic [WN_W-1:0]   WN_MEM,
  input  logic [DATA_W-1:0] RD_MEM,
  input  logic [DATA_W-1:0] ADDR_MEM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WB_WB,
  output logic [WN_W-1:0]   WN_WB,
  output logic [DATA_W-1:0] RD_WB,
  output logic [DATA_W-1:0] ADDR_WB,
  output logic              fwd_valid,
  output logic [WN_W-1:0]   fwd_wn
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_beats
`endif
);

  localparam int PW = payload_w(WB_W, WN_W, DATA_W);

  logic [PW-1:0] in_data;
  logic [PW-1:0] out_data;

  assign in_data = {WB_MEM, WN_MEM, RD_MEM, ADDR_MEM};

  pipe_skid_buf #(
    .PAYLOAD_W(PW)
  ) u_skid (
    .Clk      (Clk),
    .Rst      (Rst),
    .Flush    (Flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign {WB_WB, WN_WB, RD_WB, ADDR_WB} = out_data;

  // tap only looks at registered outputs, never at MEM inputs
  assign fwd_valid = out_valid & WB_WB[WB_W-1] & (WN_WB != '0);
  assign fwd_wn    = WN_WB;

`ifdef MEM_WB_PERF_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_stall <= '0;
      perf_beats <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (out_valid && out_ready) begin
        perf_beats <= perf_beats + 32'd1;
      end
    end
  end
`else
  // counters absent; handshake and datapath are unchanged
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of accepted
// beats plus per-scenario checks of handshake, flush and fwd tap.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int NW = 5;
  localparam int BW = 2;
  localparam int PW = BW + NW + 2 * DW;

  logic          Clk;
  logic          Rst;
  logic          Flush;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] WB_MEM;
  logic [NW-1:0] WN_MEM;
  logic [DW-1:0] RD_MEM;
  logic [DW-1:0] ADDR_MEM;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] WB_WB;
  logic [NW-1:0] WN_WB;
  logic [DW-1:0] RD_WB;
  logic [DW-1:0] ADDR_WB;
  logic          fwd_valid;
  logic [NW-1:0] fwd_wn;
`ifdef MEM_WB_PERF_EN
  logic [31:0]   perf_stall;
  logic [31:0]   perf_beats;
`endif

  int compared;
  int mismatched;
  logic [PW-1:0] sb[$];

  mem_wb_stage #(
    .DATA_W(DW),
    .WN_W  (NW),
    .WB_W  (BW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Flush    (Flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .WB_MEM   (WB_MEM),
    .WN_MEM   (WN_MEM),
    .RD_MEM   (RD_MEM),
    .ADDR_MEM (ADDR_MEM),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .WB_WB    (WB_WB),
    .WN_WB    (WN_WB),
    .RD_WB    (RD_WB),
    .ADDR_WB  (ADDR_WB),
    .fwd_valid(fwd_valid),
    .fwd_wn   (fwd_wn)
`ifdef MEM_WB_PERF_EN
    ,
    .perf_stall(perf_stall),
    .perf_beats(perf_beats)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want summary");
    $fatal(1);
  end

  // scoreboard: push on accept, compare head while valid, pop on retire
  always @(negedge Clk) begin
    if (Rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected: got beat ADDR=%h, want none",
                   ADDR_WB);
        end else if ({WB_WB, WN_WB, RD_WB, ADDR_WB} !== sb[0]) begin
          mismatched++;
          $display("FAIL sb_order: got %h, want %h",
                   {WB_WB, WN_WB, RD_WB, ADDR_WB}, sb[0]);
        end
        if (out_ready && sb.size() > 0) void'(sb.pop_front());
      end
      if (Flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back({WB_MEM, WN_MEM, RD_MEM, ADDR_MEM});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic offer(input logic [BW-1:0] wb,
                       input logic [NW-1:0] wn,
                       input logic [DW-1:0] addr);
    in_valid = 1'b1;
    WB_MEM   = wb;
    WN_MEM   = wn;
    RD_MEM   = $urandom;
    ADDR_MEM = addr;
  endtask

  task automatic test_reset();
    Rst       = 1'b1;
    out_ready = 1'b0;
    offer(2'b11, 5'd9, 32'hDEAD_BEEF);
    repeat (2) tick();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_hs: got out_valid=%b in_ready=%b, want 0/1",
               out_valid, in_ready);
    end
    compared++;
    if (WB_WB !== '0 || WN_WB !== '0 || RD_WB !== '0 ||
        ADDR_WB !== '0 || fwd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_payload: got %h %h %h %h fwd=%b, want zeros",
               WB_WB, WN_WB, RD_WB, ADDR_WB, fwd_valid);
    end
    Rst      = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [DW-1:0] a;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h10 * (i + 1);
      offer(2'b01, 5'(i + 1), a);
      tick();
      compared++;
      if (out_valid !== 1'b1 || ADDR_WB !== a || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_%0d: got v=%b addr=%h rdy=%b, want 1/%h/1",
                 i, out_valid, ADDR_WB, in_ready, a);
      end
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stream_drain: got v=%b rdy=%b, want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b1;
    offer(2'b10, 5'd3, 32'hA);
    tick();
    out_ready = 1'b0;
    offer(2'b10, 5'd4, 32'hB);
    tick();
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || ADDR_WB !== 32'hA) begin
      mismatched++;
      $display("FAIL bp_skid: got rdy=%b v=%b addr=%h, want 0/1/a",
               in_ready, out_valid, ADDR_WB);
    end
    tick();
    compared++;
    if (ADDR_WB !== 32'hA || WN_WB !== 5'd3) begin
      mismatched++;
      $display("FAIL bp_hold: got addr=%h wn=%0d, want a/3",
               ADDR_WB, WN_WB);
    end
    out_ready = 1'b1;
    tick();
    compared++;
    if (out_valid !== 1'b1 || ADDR_WB !== 32'hB || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_second: got v=%b addr=%h rdy=%b, want 1/b/1",
               out_valid, ADDR_WB, in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b0 || ADDR_WB !== 32'hB) begin
      mismatched++;
      $display("FAIL bp_last: got v=%b addr=%h, want 0/b",
               out_valid, ADDR_WB);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(2'b10, 5'd5, 32'h50);
    tick();
    offer(2'b10, 5'd6, 32'h60);
    tick();
    Flush = 1'b1;
    offer(2'b10, 5'd7, 32'h70);
    tick();
    Flush    = 1'b0;
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ADDR_WB !== '0) begin
      mismatched++;
      $display("FAIL flush_skid: got v=%b rdy=%b addr=%h, want 0/1/0",
               out_valid, in_ready, ADDR_WB);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_quiet_%0d: got v=%b addr=%h, want 0",
                 i, out_valid, ADDR_WB);
      end
    end
    offer(2'b01, 5'd8, 32'h80);
    tick();
    Flush = 1'b1;
    offer(2'b01, 5'd9, 32'h90);
    tick();
    Flush    = 1'b0;
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_full: got v=%b rdy=%b, want 0/1",
               out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_fwd();
    out_ready = 1'b1;
    offer(2'b10, 5'd7, 32'hA0);
    tick();
    compared++;
    if (fwd_valid !== 1'b1 || fwd_wn !== 5'd7) begin
      mismatched++;
      $display("FAIL fwd_hit: got fv=%b wn=%0d, want 1/7",
               fwd_valid, fwd_wn);
    end
    offer(2'b10, 5'd0, 32'hA1);
    tick();
    compared++;
    if (fwd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL fwd_r0: got fv=%b, want 0", fwd_valid);
    end
    offer(2'b00, 5'd7, 32'hA2);
    tick();
    compared++;
    if (fwd_valid !== 1'b0 || fwd_wn !== 5'd7) begin
      mismatched++;
      $display("FAIL fwd_nowr: got fv=%b wn=%0d, want 0/7",
               fwd_valid, fwd_wn);
    end
    offer(2'b11, 5'd31, 32'hA3);
    tick();
    compared++;
    if (fwd_valid !== 1'b1 || fwd_wn !== 5'd31) begin
      mismatched++;
      $display("FAIL fwd_r31: got fv=%b wn=%0d, want 1/31",
               fwd_valid, fwd_wn);
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (fwd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL fwd_idle: got fv=%b, want 0", fwd_valid);
    end
  endtask

`ifdef MEM_WB_PERF_EN
  task automatic test_perf();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    compared++;
    if (perf_beats !== 32'd0 || perf_stall !== 32'd0) begin
      mismatched++;
      $display("FAIL perf_reset: got beats=%0d stall=%0d, want 0/0",
               perf_beats, perf_stall);
    end
    out_ready = 1'b0;
    offer(2'b10, 5'd1, 32'hC0);
    tick();
    offer(2'b10, 5'd2, 32'hC1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (2) tick();
    offer(2'b10, 5'd3, 32'hC2);
    tick();
    in_valid = 1'b0;
    tick();
    compared++;
    if (perf_beats !== 32'd3 || perf_stall !== 32'd4) begin
      mismatched++;
      $display("FAIL perf_count: got beats=%0d stall=%0d, want 3/4",
               perf_beats, perf_stall);
    end
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    compared++;
    if (perf_beats !== 32'd3 || perf_stall !== 32'd4) begin
      mismatched++;
      $display("FAIL perf_flush: got beats=%0d stall=%0d, want 3/4",
               perf_beats, perf_stall);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    Rst        = 1'b1;
    Flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    WB_MEM     = '0;
    WN_MEM     = '0;
    RD_MEM     = '0;
    ADDR_MEM   = '0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_fwd();
`ifdef MEM_WB_PERF_EN
    test_perf();
`endif
    repeat (2) tick();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: got %0d beats pending, want 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
